// File: rtl/square_gen_mc_pkg.sv
// Shared types and helpers for the multi-channel phase-coherent square/PWM generator.
// Holds the run-state encoding and the per-channel slicing helpers.
package square_gen_mc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_PH_W = 12;
  localparam int DEF_DT_W = 8;

  // Bit position of channel k inside a flat CH*w bus.
  function automatic int ch_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/square_dt_ch.sv
// One output channel: phase compare against the duty threshold, followed by
// rising-edge dead-time insertion on both the main and complementary outputs.
module square_dt_ch
  import square_gen_mc_pkg::*;
#(
  parameter int PH_W = DEF_PH_W,
  parameter int DT_W = DEF_DT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PH_W-1:0] acc_top,
  input  logic [PH_W-1:0] duty,
  input  logic [PH_W-1:0] offset,
  input  logic [DT_W-1:0] dead_time,
  input  logic            en,
  output logic            square,
  output logic            square_n
);

  logic [PH_W-1:0] ph;
  logic            raw;
  logic [DT_W-1:0] cnt_p;
  logic [DT_W-1:0] cnt_n;

  assign ph  = acc_top + offset;
  assign raw = (ph < duty);

  // Each output must see its level held for dead_time cycles before it rises;
  // falling is immediate, so a short raw pulse never reaches the pin.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      square   <= 1'b0;
      square_n <= 1'b0;
      cnt_p    <= '0;
      cnt_n    <= '0;
    end else begin
      if (!raw) begin
        square <= 1'b0;
        cnt_p  <= '0;
      end else if (cnt_p >= dead_time) begin
        square <= 1'b1;
      end else begin
        cnt_p <= cnt_p + 1'b1;
      end

      if (raw) begin
        square_n <= 1'b0;
        cnt_n    <= '0;
      end else if (cnt_n >= dead_time) begin
        square_n <= 1'b1;
      end else begin
        cnt_n <= cnt_n + 1'b1;
      end
    end
  end

endmodule

// File: rtl/square_gen_mc.sv
// Multi-channel square/PWM generator: shared DDS accumulator, shadowed settings
// that reload at the period boundary, and an optional N-period burst mode.
module square_gen_mc
  import square_gen_mc_pkg::*;
#(
  parameter int CH      = 4,
  parameter int ACC_W   = 32,
  parameter int FRE_W   = 32,
  parameter int PH_W    = DEF_PH_W,
  parameter int DT_W    = DEF_DT_W,
  parameter int BURST_W = 16
) (
  input  logic                 clk_100M,
  input  logic                 rst,
  input  logic [FRE_W-1:0]     fre,
  input  logic [CH*PH_W-1:0]   duty,
  input  logic [CH*PH_W-1:0]   offset,
  input  logic [DT_W-1:0]      dead_time,
  input  logic [CH-1:0]        ch_en,
  input  logic [BURST_W-1:0]   burst_len,
  input  logic                 load,
  input  logic                 start,
  input  logic                 phase_rst,
  output logic [CH-1:0]        square,
  output logic [CH-1:0]        square_n,
  output logic                 wrap,
  output logic                 busy,
  output logic                 done
);

  state_t               state, state_d;
  logic [ACC_W-1:0]     acc, acc_d;
  logic [BURST_W-1:0]   cnt, cnt_d;
  logic                 apply, wrap_d, done_d;
  logic [ACC_W:0]       sum;
  logic [BURST_W:0]     cnt_inc;

  // Pending (written by load) and active (used by the datapath) settings.
  logic [FRE_W-1:0]     fre_p, fre_a;
  logic [CH*PH_W-1:0]   duty_p, duty_a, offset_p, offset_a;
  logic [DT_W-1:0]      dt_p, dt_a;
  logic [CH-1:0]        en_p, en_a;
  logic [BURST_W-1:0]   bl_p, bl_a;

  assign sum     = {1'b0, acc} + {{(ACC_W-FRE_W+1){1'b0}}, fre_a};
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign busy    = (state == RUN);

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    apply   = 1'b0;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    if (phase_rst) begin
      acc_d = '0;
      cnt_d = '0;
      apply = 1'b1;
    end else if (start) begin
      state_d = RUN;
      acc_d   = '0;
      cnt_d   = '0;
      apply   = 1'b1;
    end else if (state == RUN) begin
      acc_d = sum[ACC_W-1:0];
      if (sum[ACC_W]) begin
        wrap_d = 1'b1;
        apply  = 1'b1;
        cnt_d  = cnt_inc[BURST_W-1:0];
        // The burst length being applied at this wrap decides termination.
        if (bl_p != '0 && cnt_inc >= {1'b0, bl_p}) begin
          state_d = IDLE;
          done_d  = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
    end else begin
      acc_d = '0;
      apply = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; a load coinciding with an apply lands in pending
  // while active takes the older pending value.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      wrap     <= 1'b0;
      done     <= 1'b0;
      fre_p    <= '0;
      duty_p   <= '0;
      offset_p <= '0;
      dt_p     <= '0;
      en_p     <= '0;
      bl_p     <= '0;
      fre_a    <= '0;
      duty_a   <= '0;
      offset_a <= '0;
      dt_a     <= '0;
      en_a     <= '0;
      bl_a     <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
      wrap  <= wrap_d;
      done  <= done_d;
      if (load) begin
        fre_p    <= fre;
        duty_p   <= duty;
        offset_p <= offset;
        dt_p     <= dead_time;
        en_p     <= ch_en;
        bl_p     <= burst_len;
      end
      if (apply) begin
        fre_a    <= fre_p;
        duty_a   <= duty_p;
        offset_a <= offset_p;
        dt_a     <= dt_p;
        en_a     <= en_p;
        bl_a     <= bl_p;
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    square_dt_ch #(
      .PH_W (PH_W),
      .DT_W (DT_W)
    ) u_ch (
      .clk       (clk_100M),
      .rst       (rst),
      .acc_top   (acc[ACC_W-1 -: PH_W]),
      .duty      (duty_a[ch_lsb(k, PH_W) +: PH_W]),
      .offset    (offset_a[ch_lsb(k, PH_W) +: PH_W]),
      .dead_time (dt_a),
      .en        (en_a[k] && (state == RUN)),
      .square    (square[k]),
      .square_n  (square_n[k])
    );
  end

endmodule

// File: tb/tb_square_gen_mc.sv
// Directed self-checking bench for square_gen_mc: reset, basic PWM, phase offset,
// dead time, burst, mid-run reload, phase reset and reset priority.
module tb_square_gen_mc;

  localparam int CH      = 4;
  localparam int ACC_W   = 32;
  localparam int FRE_W   = 32;
  localparam int PH_W    = 12;
  localparam int DT_W    = 8;
  localparam int BURST_W = 16;

  logic                 clk_100M = 1'b0;
  logic                 rst = 1'b0;
  logic [FRE_W-1:0]     fre = '0;
  logic [CH*PH_W-1:0]   duty = '0;
  logic [CH*PH_W-1:0]   offset = '0;
  logic [DT_W-1:0]      dead_time = '0;
  logic [CH-1:0]        ch_en = '0;
  logic [BURST_W-1:0]   burst_len = '0;
  logic                 load = 1'b0;
  logic                 start = 1'b0;
  logic                 phase_rst = 1'b0;
  logic [CH-1:0]        square, square_n;
  logic                 wrap, busy, done;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [FRE_W-1:0] F16 = 32'h1000_0000;

  always #5 clk_100M = ~clk_100M;

  square_gen_mc #(
    .CH(CH), .ACC_W(ACC_W), .FRE_W(FRE_W), .PH_W(PH_W), .DT_W(DT_W), .BURST_W(BURST_W)
  ) dut (
    .clk_100M  (clk_100M),
    .rst       (rst),
    .fre       (fre),
    .duty      (duty),
    .offset    (offset),
    .dead_time (dead_time),
    .ch_en     (ch_en),
    .burst_len (burst_len),
    .load      (load),
    .start     (start),
    .phase_rst (phase_rst),
    .square    (square),
    .square_n  (square_n),
    .wrap      (wrap),
    .busy      (busy),
    .done      (done)
  );

  task automatic cfg_load(input logic [PH_W-1:0] d0, input logic [PH_W-1:0] o1,
                          input logic [DT_W-1:0] dt, input logic [CH-1:0] en,
                          input logic [BURST_W-1:0] bl);
    @(negedge clk_100M);
    fre       = F16;
    duty      = {PH_W'(2048), PH_W'(2048), PH_W'(2048), d0};
    offset    = {PH_W'(0), PH_W'(0), o1, PH_W'(0)};
    dead_time = dt;
    ch_en     = en;
    burst_len = bl;
    load      = 1'b1;
    @(negedge clk_100M);
    load = 1'b0;
  endtask

  // Returns at the negedge right after the edge that sampled start.
  task automatic pulse_start();
    @(negedge clk_100M);
    start = 1'b1;
    @(negedge clk_100M);
    start = 1'b0;
  endtask

  task automatic do_rst();
    @(negedge clk_100M);
    rst = 1'b1;
    @(negedge clk_100M);
    @(negedge clk_100M);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_rst();
    if ({square, square_n, wrap, busy, done} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset outputs got=%b exp=%b", {square, square_n, wrap, busy, done}, 11'b0);
    end
    n_run++;
  endtask

  task automatic test_basic();
    logic s;
    logic [2*CH+1:0] got, exp;
    do_rst();
    cfg_load(12'd2048, 12'd0, 8'd0, 4'b0001, 16'd0);
    pulse_start();
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk_100M);
      s   = (((i - 1) % 16) < 8);
      exp = {3'b000, s, 3'b000, ~s, (i % 16) == 0, 1'b1};
      got = {square, square_n, wrap, busy};
      if (got !== exp) begin
        n_fail++;
        $display("FAIL basic cyc=%0d got=%b exp=%b", i, got, exp);
      end
      n_run++;
    end
  endtask

  task automatic test_offset();
    logic s0, s1;
    logic [3:0] got, exp;
    do_rst();
    cfg_load(12'd2048, 12'd1024, 8'd0, 4'b0011, 16'd0);
    pulse_start();
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk_100M);
      s0  = (((i - 1) % 16) < 8);
      s1  = (((i + 3) % 16) < 8);
      exp = {s1, s0, ~s1, ~s0};
      got = {square[1:0], square_n[1:0]};
      if (got !== exp) begin
        n_fail++;
        $display("FAIL offset cyc=%0d got=%b exp=%b", i, got, exp);
      end
      n_run++;
    end
  endtask

  task automatic test_dead_time();
    int m;
    logic [1:0] got, exp;
    do_rst();
    cfg_load(12'd2048, 12'd0, 8'd3, 4'b0001, 16'd0);
    pulse_start();
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk_100M);
      m   = (i - 1) % 16;
      exp = {(m >= 3 && m <= 7), (m >= 11)};
      got = {square[0], square_n[0]};
      if (got !== exp) begin
        n_fail++;
        $display("FAIL dead_time cyc=%0d got=%b exp=%b", i, got, exp);
      end
      n_run++;
      if (square[0] && square_n[0]) begin
        n_fail++;
        $display("FAIL dead_time_overlap cyc=%0d got=11 exp=not both high", i);
      end
      n_run++;
    end
  endtask

  task automatic test_burst();
    logic [3:0] got, exp;
    do_rst();
    cfg_load(12'd2048, 12'd0, 8'd0, 4'b0001, 16'd3);
    pulse_start();
    for (int i = 1; i <= 52; i++) begin
      @(negedge clk_100M);
      exp = {(i <= 48) && (((i - 1) % 16) < 8), (i % 16) == 0 && i <= 48, i < 48, i == 48};
      got = {square[0], wrap, busy, done};
      if (got !== exp) begin
        n_fail++;
        $display("FAIL burst cyc=%0d got=%b exp=%b", i, got, exp);
      end
      n_run++;
    end
  endtask

  task automatic test_reload();
    logic s;
    do_rst();
    cfg_load(12'd2048, 12'd0, 8'd0, 4'b0001, 16'd0);
    pulse_start();
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk_100M);
      s = (i <= 16) ? (((i - 1) % 16) < 8) : (((i - 1) % 16) < 4);
      if (square[0] !== s) begin
        n_fail++;
        $display("FAIL reload cyc=%0d got=%b exp=%b", i, square[0], s);
      end
      n_run++;
      if (i == 3) begin
        duty[PH_W-1:0] = 12'd1024;
        load = 1'b1;
      end else if (i == 4) begin
        load = 1'b0;
      end
    end
  endtask

  task automatic test_phase_rst();
    logic [1:0] got, exp;
    do_rst();
    cfg_load(12'd2048, 12'd0, 8'd0, 4'b0001, 16'd0);
    pulse_start();
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk_100M);
      exp[1] = (i <= 8) ? 1'b1 : (((i - 9) % 16) < 4);
      exp[0] = (i == 24);
      got    = {square[0], wrap};
      if (got !== exp) begin
        n_fail++;
        $display("FAIL phase_rst cyc=%0d got=%b exp=%b", i, got, exp);
      end
      n_run++;
      if (i == 3) begin
        duty[PH_W-1:0] = 12'd1024;
        load = 1'b1;
      end else if (i == 4) begin
        load = 1'b0;
      end else if (i == 7) begin
        phase_rst = 1'b1;
      end else if (i == 8) begin
        phase_rst = 1'b0;
      end
    end
  endtask

  task automatic test_rst_priority();
    do_rst();
    cfg_load(12'd2048, 12'd0, 8'd0, 4'b1111, 16'd0);
    pulse_start();
    repeat (3) @(negedge clk_100M);
    rst       = 1'b1;
    phase_rst = 1'b1;
    start     = 1'b1;
    @(negedge clk_100M);
    rst       = 1'b0;
    phase_rst = 1'b0;
    start     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ({square, square_n, wrap, busy, done} !== 11'b0) begin
        n_fail++;
        $display("FAIL rst_priority cyc=%0d got=%b exp=%b", i,
                 {square, square_n, wrap, busy, done}, 11'b0);
      end
      n_run++;
      @(negedge clk_100M);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_offset();
    test_dead_time();
    test_burst();
    test_reload();
    test_phase_rst();
    test_rst_priority();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
